alu_rs: RTL
===========

Name: alu_rs

Overview:
Reservation station and issue scheduler for the single-cycle ALU. It holds up to RS_SIZE dispatched ALU micro-ops and captures operand values from the ALU and LSB result broadcasts. Each cycle it selects one operand-ready entry and drives the ALU's cal_signal/opcode/lhs/rhs/tag inputs. It sits between the decoder/dispatch stage and the ALU; the ROB flushes it on mispredict.

Parameters:
ROB_WIDTH, 4, width of ROB tags (tag space 0..2^ROB_WIDTH-1)
RS_WIDTH, 3, log2 of entry count
RS_SIZE, 8, number of entries (= 2^RS_WIDTH)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  pause; when low all state is frozen
flush_in  input  1  clear all entries (ROB mispredict)
disp_valid  input  1  dispatch a new op this cycle
disp_opcode  input  4  ALU opcode (AND=1 .. JALR=15)
disp_vj / disp_vk  input  32  operand values, valid when matching ready bit is 1
disp_qj / disp_qk  input  ROB_WIDTH  producer tags, used when ready bit is 0
disp_rj / disp_rk  input  1  operand already available
disp_tag  input  ROB_WIDTH  destination ROB tag
full  output  1  no free entry (combinational from valid bits)
alu_done / lsb_done  input  1  result broadcast valid
alu_result / lsb_result  input  32  broadcast value
alu_tag / lsb_tag  input  ROB_WIDTH  broadcast tag
cal_signal  output  1  issue strobe to ALU (registered)
cal_opcode  output  4  issued opcode (registered)
cal_lhs / cal_rhs  output  32  issued operands (registered)
cal_tag  output  ROB_WIDTH  issued ROB tag (registered)

Behaviour:
- Reset (rst_n_in low, asynchronous): all entry valid bits 0; cal_signal 0; cal_opcode, cal_lhs, cal_rhs, cal_tag 0; full 0. Entry payloads are don't-care.
- rdy_in low: no state changes, outputs hold. The ALU is also frozen, so a held cal_signal is not re-consumed.
- Entry fields: valid, opcode, vj, vk, qj, qk, rj, rk, tag.
- Wakeup (each rdy cycle): for every valid entry with rj=0 and qj==alu_tag while alu_done, set vj<=alu_result and rj<=1. Apply the same rule for lsb and for the k operand. If both buses match the same operand tag, the ALU bus wins (this should not occur legally).
- Dispatch: when disp_valid && !full && !flush_in, write the lowest-index free entry. A dispatch operand with r=0 whose q matches a broadcast in the same cycle is captured as ready with the broadcast value. disp_valid while full is ignored, and the dispatcher must not do this.
- Select: the candidate is the lowest-index entry with valid && rj && rk, using start-of-cycle state. An entry woken this cycle becomes eligible next cycle.
- Issue: when a candidate exists, at the clock edge set cal_signal<=1, load cal_* from the entry, and clear its valid bit. Otherwise cal_signal<=0. Throughput is one issue per cycle. Latency from dispatch with both operands ready to cal_signal high is 2 edges: write at edge 1, issue at edge 2.
- Simultaneous issue and dispatch: the slot freed by issue is not reusable until the next cycle. full is computed from start-of-cycle valid bits.
- Flush: on the next edge all valid bits clear and cal_signal<=0. Flush has priority over dispatch, wakeup and issue. Flush asserted together with reset: reset dominates.
- full = &valid (all RS_SIZE entries valid).

Decomposition:
- Shared package: REG_WIDTH=32, OPCODE_ALU_WIDTH=4, ALU opcode constants (AND..JALR), and a rs_entry struct typedef reused by the LSB queue.
- Sub-module: prio_enc (parameterised lowest-index-set-bit finder returning index + found flag). Instantiate it twice: free-slot search and ready-entry select.

Test Plan:
- Reset then dispatch ADD, vj=5, vk=7, rj=rk=1, tag=3 → two edges later cal_signal=1 for one cycle with cal_opcode=4, lhs=5, rhs=7, tag=3.
- Dispatch SUB with qj=2, rj=0, vk=1; hold 3 cycles → no issue. Then alu_done, tag=2, result=10 → cal_signal one cycle later with lhs=10, rhs=1.
- Dispatch with qk=6 in the same cycle as lsb_done, tag=6, result=0xDEADBEEF → entry captured ready; issues next edge with rhs=0xDEADBEEF.
- Fill 8 entries with unready ops → full=1, and a 9th dispatch is ignored. Wake entries 5 and 2 in the same cycle → issue order is index 2 then 5 on consecutive cycles; full drops after the first issue.
- Fill 4 ready entries then pulse flush_in → cal_signal=0 on the next edge, full=0, no further issues. A new dispatch afterwards issues normally.
- Issue pending, then drop rdy_in for 3 cycles while alu_done toggles → no state change. Raise rdy_in → issue resumes with the correct values; an async rst_n_in low mid-stream clears cal_signal immediately.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station and its neighbours.
// The rs_entry_t layout is also used by the LSB queue, so keep field order stable.
package alu_rs_pkg;

    localparam int REG_WIDTH        = 32;
    localparam int OPCODE_ALU_WIDTH = 4;
    localparam int TAG_WIDTH        = 4;   // ROB tag width baked into rs_entry_t

    // ALU opcodes; 0 is left unused so an all-zero opcode never looks like a real op
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_AND  = 4'd1;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_OR   = 4'd2;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_XOR  = 4'd3;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_ADD  = 4'd4;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SUB  = 4'd5;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SLL  = 4'd6;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SRL  = 4'd7;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SRA  = 4'd8;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SLT  = 4'd9;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_SLTU = 4'd10;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_EQ   = 4'd11;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_NE   = 4'd12;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_GE   = 4'd13;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_GEU  = 4'd14;
    localparam logic [OPCODE_ALU_WIDTH-1:0] ALU_JALR = 4'd15;

    // One waiting micro-op: operand value is meaningful when its r bit is set,
    // otherwise q names the ROB entry that will produce it.
    typedef struct packed {
        logic                        valid;
        logic [OPCODE_ALU_WIDTH-1:0] opcode;
        logic [REG_WIDTH-1:0]        vj;
        logic [REG_WIDTH-1:0]        vk;
        logic [TAG_WIDTH-1:0]        qj;
        logic [TAG_WIDTH-1:0]        qk;
        logic                        rj;
        logic                        rk;
        logic [TAG_WIDTH-1:0]        tag;
    } rs_entry_t;

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-index set-bit finder: returns the index of the first request bit
// and a flag telling whether any bit was set at all.
module prio_enc #(
    parameter int WIDTH     = 8,
    parameter int IDX_WIDTH = 3
) (
    input  logic [WIDTH-1:0]     req,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 found
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = i[IDX_WIDTH-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ALU ops, snoops the ALU and LSB
// result buses for missing operands, and issues one ready op per cycle.
// ROB_WIDTH must match TAG_WIDTH in the package since entries use rs_entry_t.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int ROB_WIDTH = TAG_WIDTH,
    parameter int RS_WIDTH  = 3,
    parameter int RS_SIZE   = 1 << RS_WIDTH
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        rdy_in,
    input  logic                        flush_in,
    input  logic                        disp_valid,
    input  logic [OPCODE_ALU_WIDTH-1:0] disp_opcode,
    input  logic [REG_WIDTH-1:0]        disp_vj,
    input  logic [REG_WIDTH-1:0]        disp_vk,
    input  logic [ROB_WIDTH-1:0]        disp_qj,
    input  logic [ROB_WIDTH-1:0]        disp_qk,
    input  logic                        disp_rj,
    input  logic                        disp_rk,
    input  logic [ROB_WIDTH-1:0]        disp_tag,
    output logic                        full,
    input  logic                        alu_done,
    input  logic [REG_WIDTH-1:0]        alu_result,
    input  logic [ROB_WIDTH-1:0]        alu_tag,
    input  logic                        lsb_done,
    input  logic [REG_WIDTH-1:0]        lsb_result,
    input  logic [ROB_WIDTH-1:0]        lsb_tag,
    output logic                        cal_signal,
    output logic [OPCODE_ALU_WIDTH-1:0] cal_opcode,
    output logic [REG_WIDTH-1:0]        cal_lhs,
    output logic [REG_WIDTH-1:0]        cal_rhs,
    output logic [ROB_WIDTH-1:0]        cal_tag
);

    rs_entry_t entry_reg  [RS_SIZE];
    rs_entry_t entry_next [RS_SIZE];
    rs_entry_t disp_entry;

    logic [RS_SIZE-1:0]  valid_vec;
    logic [RS_SIZE-1:0]  ready_vec;
    logic [RS_WIDTH-1:0] free_idx;
    logic [RS_WIDTH-1:0] sel_idx;
    logic                free_found;
    logic                sel_found;
    logic                disp_fire;

    logic                        cal_signal_reg;
    logic [OPCODE_ALU_WIDTH-1:0] cal_opcode_reg;
    logic [REG_WIDTH-1:0]        cal_lhs_reg;
    logic [REG_WIDTH-1:0]        cal_rhs_reg;
    logic [ROB_WIDTH-1:0]        cal_tag_reg;

    // Per-entry occupancy and readiness, both from start-of-cycle state
    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_flags
            assign valid_vec[gi] = entry_reg[gi].valid;
            assign ready_vec[gi] = entry_reg[gi].valid & entry_reg[gi].rj & entry_reg[gi].rk;
        end
    endgenerate

    assign full      = &valid_vec;
    assign disp_fire = disp_valid && free_found && !flush_in;

    prio_enc #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_WIDTH)) u_free_enc (
        .req   (~valid_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    prio_enc #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_WIDTH)) u_sel_enc (
        .req   (ready_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Build the incoming entry, grabbing an operand that is broadcast this very cycle
    always_comb begin
        disp_entry        = '0;
        disp_entry.valid  = 1'b1;
        disp_entry.opcode = disp_opcode;
        disp_entry.tag    = disp_tag;
        disp_entry.qj     = disp_qj;
        disp_entry.qk     = disp_qk;
        disp_entry.vj     = disp_vj;
        disp_entry.vk     = disp_vk;
        disp_entry.rj     = disp_rj;
        disp_entry.rk     = disp_rk;
        if (!disp_rj) begin
            if (alu_done && disp_qj == alu_tag) begin
                disp_entry.vj = alu_result;
                disp_entry.rj = 1'b1;
            end else if (lsb_done && disp_qj == lsb_tag) begin
                disp_entry.vj = lsb_result;
                disp_entry.rj = 1'b1;
            end
        end
        if (!disp_rk) begin
            if (alu_done && disp_qk == alu_tag) begin
                disp_entry.vk = alu_result;
                disp_entry.rk = 1'b1;
            end else if (lsb_done && disp_qk == lsb_tag) begin
                disp_entry.vk = lsb_result;
                disp_entry.rk = 1'b1;
            end
        end
    end

    // Next entry state: wakeup, then issue, then dispatch, with flush overriding all
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entry_next[i] = entry_reg[i];
            if (entry_reg[i].valid && !entry_reg[i].rj) begin
                if (alu_done && entry_reg[i].qj == alu_tag) begin
                    entry_next[i].vj = alu_result;
                    entry_next[i].rj = 1'b1;
                end else if (lsb_done && entry_reg[i].qj == lsb_tag) begin
                    entry_next[i].vj = lsb_result;
                    entry_next[i].rj = 1'b1;
                end
            end
            if (entry_reg[i].valid && !entry_reg[i].rk) begin
                if (alu_done && entry_reg[i].qk == alu_tag) begin
                    entry_next[i].vk = alu_result;
                    entry_next[i].rk = 1'b1;
                end else if (lsb_done && entry_reg[i].qk == lsb_tag) begin
                    entry_next[i].vk = lsb_result;
                    entry_next[i].rk = 1'b1;
                end
            end
            if (sel_found && sel_idx == i[RS_WIDTH-1:0]) begin
                entry_next[i].valid = 1'b0;
            end
            // free_idx only points at slots empty at cycle start, so never the issued one
            if (disp_fire && free_idx == i[RS_WIDTH-1:0]) begin
                entry_next[i] = disp_entry;
            end
            if (flush_in) begin
                entry_next[i].valid = 1'b0;
            end
        end
    end

    // Entry storage; everything freezes while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            entry_reg <= '{default: '0};
        end else if (rdy_in) begin
            entry_reg <= entry_next;
        end
    end

    // Registered issue port toward the ALU
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cal_signal_reg <= 1'b0;
            cal_opcode_reg <= '0;
            cal_lhs_reg    <= '0;
            cal_rhs_reg    <= '0;
            cal_tag_reg    <= '0;
        end else if (rdy_in) begin
            if (flush_in || !sel_found) begin
                cal_signal_reg <= 1'b0;
            end else begin
                cal_signal_reg <= 1'b1;
                cal_opcode_reg <= entry_reg[sel_idx].opcode;
                cal_lhs_reg    <= entry_reg[sel_idx].vj;
                cal_rhs_reg    <= entry_reg[sel_idx].vk;
                cal_tag_reg    <= entry_reg[sel_idx].tag;
            end
        end
    end

    assign cal_signal = cal_signal_reg;
    assign cal_opcode = cal_opcode_reg;
    assign cal_lhs    = cal_lhs_reg;
    assign cal_rhs    = cal_rhs_reg;
    assign cal_tag    = cal_tag_reg;

endmodule
